// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch front end of the 5-stage CPU.
//   XLEN        datapath width
//   OP_*        instr[6:2] encodings for control-transfer instructions
//   pc_state_e  fetch sequencer states
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT,
    PEND
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux.
//   Priority: trap_req -> trap_vector, redirect -> jb_target,
//   stall -> pc (hold), otherwise pc + 4 (wraps modulo 2^XLEN).
// Ports:
//   pc, ex_valid, ex_opcode, branch_taken, jb_target, stall,
//   trap_req, trap_vector            inputs
//   next_pc                          selected next fetch PC
//   redirect_req                     EX holds a taken jump/branch (drives flushes)
//   redirect                         redirect actually followed by the PC
//   misalign                         (PC_REDIRECT_MISALIGN_EN only) redirect
//                                    dropped because jb_target[1] is set
// Configuration macro: PC_REDIRECT_MISALIGN_EN
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            ex_valid,
  input  logic [4:0]      ex_opcode,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] jb_target,
  input  logic            stall,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_req,
  output logic            redirect
`ifdef PC_REDIRECT_MISALIGN_EN
  , output logic          misalign
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  always_comb begin
    redirect_req = ex_valid &&
                   ((ex_opcode == OP_JAL) ||
                    (ex_opcode == OP_JALR) ||
                    ((ex_opcode == OP_BRANCH) && branch_taken));
`ifdef PC_REDIRECT_MISALIGN_EN
    misalign = redirect_req && jb_target[1];
    redirect = redirect_req && !jb_target[1];
`else
    redirect = redirect_req;
`endif
    next_pc = pc + PC_STEP;
    if (trap_req) begin
      next_pc = trap_vector;
    end else if (redirect) begin
      next_pc = jb_target;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer with jump/branch/trap redirect.
// Arbitrates trap / redirect / stall / sequential next-PC sources, handshakes
// with the instruction memory, parks a redirect that arrives while a fetch is
// outstanding (PEND) and marks that stale fetch with fetch_discard.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ex_valid, ex_opcode, branch_taken, jb_target   EX-stage control transfer
//   stall             hazard hold of PC and IF/ID
//   trap_req, trap_vector                          trap redirect
//   im_ready          instruction memory handshake
//   im_req, im_addr   fetch request / address (im_addr == pc)
//   pc                current fetch PC
//   flush_if_id, flush_id_ex   one-cycle kill pulses on trap/redirect
//   fetch_discard     completing fetch is stale
//   misalign_trap     (PC_REDIRECT_MISALIGN_EN only) redirect to a target
//                     with bit 1 set was dropped
// Configuration macro: PC_REDIRECT_MISALIGN_EN
module pc_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [4:0]      ex_opcode,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] jb_target,
  input  logic            stall,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            im_ready,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  output logic [XLEN-1:0] pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            fetch_discard
`ifdef PC_REDIRECT_MISALIGN_EN
  , output logic          misalign_trap
`endif
);

  pc_state_e       state;
  pc_state_e       state_nx;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] next_pc;
  logic            redirect_req;
  logic            redirect;
  logic            pc_event;
`ifdef PC_REDIRECT_MISALIGN_EN
  logic            misalign;
`endif

  next_pc_sel u_next_pc_sel (
    .pc           (pc_q),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .branch_taken (branch_taken),
    .jb_target    (jb_target),
    .stall        (stall),
    .trap_req     (trap_req),
    .trap_vector  (trap_vector),
    .next_pc      (next_pc),
    .redirect_req (redirect_req),
    .redirect     (redirect)
`ifdef PC_REDIRECT_MISALIGN_EN
    , .misalign   (misalign)
`endif
  );

  // An event that changes the PC stream (a dropped misaligned redirect is not one)
  assign pc_event = trap_req || redirect;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (!im_ready) begin
          state_nx = pc_event ? PEND : WAIT;
        end
      end
      WAIT: begin
        if (im_ready) begin
          state_nx = RUN;
        end else if (pc_event) begin
          state_nx = PEND;
        end
      end
      PEND: begin
        if (im_ready) begin
          state_nx = RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    im_req        = (state != BOOT);
    flush_if_id   = (state != BOOT) && (trap_req || redirect_req);
    flush_id_ex   = (state != BOOT) && (trap_req || redirect_req);
    fetch_discard = (state == PEND) && im_ready;
`ifdef PC_REDIRECT_MISALIGN_EN
    misalign_trap = (state != BOOT) && misalign;
`endif
  end

  // PC and parked redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      pend_pc <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (im_ready) begin
            pc_q <= next_pc;
          end else if (pc_event) begin
            pend_pc <= next_pc;
          end
        end
        WAIT: begin
          // The outstanding fetch completes in the same cycle as the event:
          // take the target directly rather than parking it.
          if (im_ready) begin
            if (pc_event) begin
              pc_q <= next_pc;
            end
          end else if (pc_event) begin
            pend_pc <= next_pc;
          end
        end
        PEND: begin
          // A trap seen while parked replaces the target, including in the
          // completing cycle itself.
          if (trap_req) begin
            pend_pc <= trap_vector;
          end
          if (im_ready) begin
            pc_q <= trap_req ? trap_vector : pend_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc      = pc_q;
  assign im_addr = pc_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
  import cpu_pkg::*;

  localparam logic [4:0] OJ  = 5'b11011;
  localparam logic [4:0] OJR = 5'b11001;
  localparam logic [4:0] OBR = 5'b11000;

`ifdef PC_REDIRECT_MISALIGN_EN
  localparam logic [31:0] MIS_PC  = 32'h0000_0004;
  localparam logic        MIS_EXP = 1'b1;
`else
  localparam logic [31:0] MIS_PC  = 32'h0000_0202;
  localparam logic        MIS_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic        branch_taken;
  logic [31:0] jb_target;
  logic        stall;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        im_ready;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        fetch_discard;
`ifdef PC_REDIRECT_MISALIGN_EN
  logic        misalign_trap;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .branch_taken  (branch_taken),
    .jb_target     (jb_target),
    .stall         (stall),
    .trap_req      (trap_req),
    .trap_vector   (trap_vector),
    .im_ready      (im_ready),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .pc            (pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .fetch_discard (fetch_discard)
`ifdef PC_REDIRECT_MISALIGN_EN
    , .misalign_trap (misalign_trap)
`endif
  );

  typedef struct {
    logic        ev;
    logic [4:0]  op;
    logic        tk;
    logic [31:0] tgt;
    logic        st;
    logic        tr;
    logic [31:0] tv;
    logic        rdy;
    logic [31:0] pc_pre;
    logic        req;
    logic        fl;
    logic        disc;
    pc_state_e   state;
    logic [31:0] pc_post;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ev, logic [4:0] op, logic tk, logic [31:0] tgt,
                              logic st, logic tr, logic [31:0] tv, logic rdy,
                              logic [31:0] pc_pre, logic req, logic fl, logic disc,
                              pc_state_e state, logic [31:0] pc_post, logic mis);
    vec_t v;
    v = '{ev, op, tk, tgt, st, tr, tv, rdy, pc_pre, req, fl, disc, state, pc_post, mis};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_valid     = v.ev;
    ex_opcode    = v.op;
    branch_taken = v.tk;
    jb_target    = v.tgt;
    stall        = v.st;
    trap_req     = v.tr;
    trap_vector  = v.tv;
    im_ready     = v.rdy;
  endtask

  task automatic idle_inputs(input logic rdy);
    ex_valid = 0; ex_opcode = '0; branch_taken = 0; jb_target = '0;
    stall = 0; trap_req = 0; trap_vector = '0; im_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ev op tk tgt st tr tv rdy | pc_pre req fl disc state | pc_post mis
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h0,        0, 0, 0, BOOT, 32'h0,        0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h0,        1, 0, 0, RUN,  32'h4,        0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h4,        1, 0, 0, RUN,  32'h8,        0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h8,        1, 0, 0, RUN,  32'hC,        0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'hC,        1, 0, 0, RUN,  32'h10,       0));
    vecs.push_back(mk(1, OJ,   0, 32'h200,      0, 0, 32'h0,    1, 32'h10,       1, 1, 0, RUN,  32'h200,      0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h200,      1, 0, 0, RUN,  32'h204,      0));
    vecs.push_back(mk(1, OBR,  1, 32'h80,       1, 0, 32'h0,    1, 32'h204,      1, 1, 0, RUN,  32'h80,       0));
    vecs.push_back(mk(1, OBR,  0, 32'h500,      1, 0, 32'h0,    1, 32'h80,       1, 0, 0, RUN,  32'h80,       0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        1, 0, 32'h0,    1, 32'h80,       1, 0, 0, RUN,  32'h80,       0));
    vecs.push_back(mk(0, OJR,  0, 32'h900,      0, 0, 32'h0,    1, 32'h80,       1, 0, 0, RUN,  32'h84,       0));
    vecs.push_back(mk(1, OJ,   0, 32'h40,       0, 0, 32'h0,    1, 32'h84,       1, 1, 0, RUN,  32'h40,       0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h40,       1, 0, 0, RUN,  32'h40,       0));
    vecs.push_back(mk(1, OJR,  0, 32'h300,      0, 0, 32'h0,    0, 32'h40,       1, 1, 0, WAIT, 32'h40,       0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h40,       1, 0, 0, PEND, 32'h40,       0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h40,       1, 0, 1, PEND, 32'h300,      0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h300,      1, 0, 0, RUN,  32'h304,      0));
    vecs.push_back(mk(1, OJ,   0, 32'h200,      0, 1, 32'h1000, 1, 32'h304,      1, 1, 0, RUN,  32'h1000,     0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 1, 32'h2000, 0, 32'h1000,     1, 1, 0, RUN,  32'h1000,     0));
    vecs.push_back(mk(1, OJ,   0, 32'h700,      0, 0, 32'h0,    0, 32'h1000,     1, 1, 0, PEND, 32'h1000,     0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 1, 32'h3000, 0, 32'h1000,     1, 1, 0, PEND, 32'h1000,     0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h1000,     1, 0, 1, PEND, 32'h3000,     0));
    vecs.push_back(mk(1, OJ,   0, 32'hFFFF_FFFC,0, 0, 32'h0,    1, 32'h3000,     1, 1, 0, RUN,  32'hFFFF_FFFC,0));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, 32'hFFFF_FFFC,1, 0, 0, RUN,  32'h0,        0));
    vecs.push_back(mk(1, OJ,   0, 32'h202,      0, 0, 32'h0,    1, 32'h0,        1, 1, 0, RUN,  MIS_PC,       MIS_EXP));
    vecs.push_back(mk(0, 5'b0, 0, 32'h0,        0, 0, 32'h0,    1, MIS_PC,       1, 0, 0, RUN,  MIS_PC + 32'h4, 0));

    rst_n = 1'b0;
    idle_inputs(1'b1);
    #1;
    check("rst_pc",      pc, 32'h0);
    check("rst_im_addr", im_addr, 32'h0);
    check("rst_im_req",  32'(im_req), 32'h0);
    check("rst_flush_if_id", 32'(flush_if_id), 32'h0);
    check("rst_flush_id_ex", 32'(flush_id_ex), 32'h0);
    check("rst_discard", 32'(fetch_discard), 32'h0);
    check("rst_state",   32'(dut.state), 32'(BOOT));
`ifdef PC_REDIRECT_MISALIGN_EN
    check("rst_misalign", 32'(misalign_trap), 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_pc_pre", i),   pc, vecs[i].pc_pre);
      check($sformatf("v%0d_im_addr", i),  im_addr, vecs[i].pc_pre);
      check($sformatf("v%0d_im_req", i),   32'(im_req), 32'(vecs[i].req));
      check($sformatf("v%0d_flush_if_id", i), 32'(flush_if_id), 32'(vecs[i].fl));
      check($sformatf("v%0d_flush_id_ex", i), 32'(flush_id_ex), 32'(vecs[i].fl));
      check($sformatf("v%0d_discard", i),  32'(fetch_discard), 32'(vecs[i].disc));
      check($sformatf("v%0d_state", i),    32'(dut.state), 32'(vecs[i].state));
`ifdef PC_REDIRECT_MISALIGN_EN
      check($sformatf("v%0d_misalign", i), 32'(misalign_trap), 32'(vecs[i].mis));
`endif
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc_post", i),  pc, vecs[i].pc_post);
      @(negedge clk);
    end

    // Park a redirect in PEND, then reset asynchronously mid-cycle.
    idle_inputs(1'b0);
    ex_valid  = 1'b1;
    ex_opcode = OJ;
    jb_target = 32'h600;
    @(posedge clk);
    #1;
    check("pend_state", 32'(dut.state), 32'(PEND));
    check("pend_pc_hold", pc, MIS_PC + 32'h4);
    check("pend_target", dut.pend_pc, 32'h600);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",      pc, 32'h0);
    check("arst_state",   32'(dut.state), 32'(BOOT));
    check("arst_im_req",  32'(im_req), 32'h0);
    check("arst_pend_pc", dut.pend_pc, 32'h0);
    check("arst_flush",   32'(flush_if_id), 32'h0);

    // Events during BOOT are ignored.
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs(1'b1);
    trap_req    = 1'b1;
    trap_vector = 32'h5000;
    #1;
    check("boot_flush_if_id", 32'(flush_if_id), 32'h0);
    check("boot_flush_id_ex", 32'(flush_id_ex), 32'h0);
    check("boot_im_req",      32'(im_req), 32'h0);
    @(posedge clk);
    #1;
    check("boot_pc_post",  pc, 32'h0);
    check("boot_state",    32'(dut.state), 32'(RUN));
    @(negedge clk);
    idle_inputs(1'b1);
    #1;
    check("run_im_req", 32'(im_req), 32'h1);
    @(posedge clk);
    #1;
    check("run_pc_step", pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
